// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_disp_pkg
// Brief    : Shared types and segment constants for the hex display controller.
// Revision : 1.0 - initial release
// ============================================================================
package hex_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // One displayed digit: nibble plus override flags (blank wins over dash)
    typedef struct packed {
        logic       blank;
        logic       dash;
        logic [3:0] val;
    } digit_code_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_decode
// Brief    : Digit code to active-low 7-segment pattern, bit order g..a.
// Revision : 1.0 - initial release
// ============================================================================
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  digit_code_t i_code,
    output logic [6:0]  o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_code.blank) begin
            o_seg = SEG_BLANK;
        end else if (i_code.dash) begin
            o_seg = SEG_DASH;
        end else begin
            case (i_code.val)
                4'h0: o_seg = 7'b1000000;
                4'h1: o_seg = 7'b1111001;
                4'h2: o_seg = 7'b0100100;
                4'h3: o_seg = 7'b0110000;
                4'h4: o_seg = 7'b0011001;
                4'h5: o_seg = 7'b0010010;
                4'h6: o_seg = 7'b0000010;
                4'h7: o_seg = 7'b1111000;
                4'h8: o_seg = 7'b0000000;
                4'h9: o_seg = 7'b0011000;
                4'hA: o_seg = 7'b0001000;
                4'hB: o_seg = 7'b0000011;
                4'hC: o_seg = 7'b1000110;
                4'hD: o_seg = 7'b0100001;
                4'hE: o_seg = 7'b0000110;
                4'hF: o_seg = 7'b0001110;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Brief    : Multi-digit active-low 7-segment controller, hex or decimal
//            (double-dabble) with LZ suppression, enables, blink, overflow.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      dec_mode,
    input  logic                      lz_suppress,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [7*NUM_DIGITS-1:0]   HEX,
    output logic                      busy,
    output logic                      overflow
);

    localparam int W          = 4 * NUM_DIGITS;
    localparam int CONV_CNT_W = $clog2(W);
    localparam int BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [CONV_CNT_W-1:0] CONV_LAST = CONV_CNT_W'(W - 1);
    localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(BLINK_HALF - 1);

    state_t                         state_q, state_d;
    logic [CONV_CNT_W-1:0]          cnt_q, cnt_d;
    logic [W-1:0]                   bin_q, bin_d;
    logic [W-1:0]                   bcd_q, bcd_d;
    logic [W-1:0]                   bcd_adj;
    logic                           ovf_acc_q, ovf_acc_d;
    logic                           dec_q, dec_d;
    logic                           lz_q, lz_d;
    logic [NUM_DIGITS-1:0]          en_pend_q, en_pend_d;
    logic [NUM_DIGITS-1:0]          mask_pend_q, mask_pend_d;
    logic [NUM_DIGITS-1:0]          en_q, en_d;
    logic [NUM_DIGITS-1:0]          mask_q, mask_d;
    digit_code_t [NUM_DIGITS-1:0]   digits_q, digits_d, digits_upd;
    logic                           overflow_q, overflow_d;
    logic [7*NUM_DIGITS-1:0]        hex_q, hex_d;
    logic [BLK_W-1:0]               blink_cnt_q, blink_cnt_d;
    logic                           phase_q, phase_d;
    logic [W-1:0]                   src;
    logic                           ovf_show;

    // Add-3 correction applied to every BCD digit before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Any bit shifted out of the top digit means value >= 10^NUM_DIGITS
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        ovf_acc_d   = ovf_acc_q;
        dec_d       = dec_q;
        lz_d        = lz_q;
        en_pend_d   = en_pend_q;
        mask_pend_d = mask_pend_q;
        en_d        = en_q;
        mask_d      = mask_q;
        digits_d    = digits_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d       = value;
                    bcd_d       = '0;
                    ovf_acc_d   = 1'b0;
                    cnt_d       = '0;
                    dec_d       = dec_mode;
                    lz_d        = lz_suppress;
                    en_pend_d   = digit_en;
                    mask_pend_d = blink_mask;
                    state_d     = dec_mode ? CONVERT : UPDATE;
                end
            end
            CONVERT: begin
                bcd_d     = {bcd_adj[W-2:0], bin_q[W-1]};
                bin_d     = {bin_q[W-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | bcd_adj[W-1];
                cnt_d     = cnt_q + CONV_CNT_W'(1);
                if (cnt_q == CONV_LAST) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                digits_d   = digits_upd;
                en_d       = en_pend_q;
                mask_d     = mask_pend_q;
                overflow_d = ovf_show;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign src      = dec_q ? bcd_q : bin_q;
    assign ovf_show = dec_q & ovf_acc_q;

    // Dashes count as significant digits, so overflow disables zero blanking
    always_comb begin
        logic lead;
        digits_upd = '0;
        lead       = lz_q;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digits_upd[i].val  = src[4*i +: 4];
            digits_upd[i].dash = ovf_show;
            if (lead && !ovf_show && (i != 0) && (src[4*i +: 4] == 4'd0)) begin
                digits_upd[i].blank = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end

    always_comb begin
        if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
            phase_d     = phase_q;
        end
    end

    // Display is built from the next latch contents so an update shows one cycle after UPDATE
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        digit_code_t shown;

        always_comb begin
            shown = digits_d[g];
            if (!en_d[g] || (mask_d[g] && phase_q)) begin
                shown.blank = 1'b1;
            end
        end

        hex_seg_decode u_dec (
            .i_code (shown),
            .o_seg  (hex_d[7*g +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            ovf_acc_q   <= 1'b0;
            dec_q       <= 1'b0;
            lz_q        <= 1'b0;
            en_pend_q   <= '0;
            mask_pend_q <= '0;
            en_q        <= '0;
            mask_q      <= '0;
            digits_q    <= '0;
            overflow_q  <= 1'b0;
            hex_q       <= '1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            ovf_acc_q   <= ovf_acc_d;
            dec_q       <= dec_d;
            lz_q        <= lz_d;
            en_pend_q   <= en_pend_d;
            mask_pend_q <= mask_pend_d;
            en_q        <= en_d;
            mask_q      <= mask_d;
            digits_q    <= digits_d;
            overflow_q  <= overflow_d;
            hex_q       <= hex_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign HEX      = hex_q;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_ctrl
// Brief    : Self-checking bench for hex_display_ctrl against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

    localparam int NUM_DIGITS = 6;
    localparam int W          = 4 * NUM_DIGITS;
    localparam int BLINK_HALF = 4;
    localparam int DEC_LAT    = W + 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     load = 1'b0;
    logic [W-1:0]             value = '0;
    logic                     dec_mode = 1'b0;
    logic                     lz_suppress = 1'b0;
    logic [NUM_DIGITS-1:0]    digit_en = '0;
    logic [NUM_DIGITS-1:0]    blink_mask = '0;
    logic [7*NUM_DIGITS-1:0]  HEX;
    logic                     busy;
    logic                     overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int bticks   = 0;

    logic [6:0] seg_tab [16];

    // Model of what the display currently holds
    logic [W-1:0]          m_v    = '0;
    logic                  m_dec  = 1'b0;
    logic                  m_lz   = 1'b0;
    logic [NUM_DIGITS-1:0] m_en   = '0;
    logic [NUM_DIGITS-1:0] m_mask = '0;

    hex_display_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .dec_mode    (dec_mode),
        .lz_suppress (lz_suppress),
        .digit_en    (digit_en),
        .blink_mask  (blink_mask),
        .HEX         (HEX),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset released
    always @(posedge clk) begin
        if (reset) bticks <= 0;
        else       bticks <= bticks + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // HEX after k edges reflects the phase held after k-1 edges
    function automatic logic exp_phase();
        if (bticks == 0) return 1'b0;
        return ((((bticks - 1) / BLINK_HALF) % 2) == 1);
    endfunction

    function automatic logic [7*NUM_DIGITS-1:0] model_hex(
        input logic [W-1:0] v, input logic d, input logic lz,
        input logic [NUM_DIGITS-1:0] en, input logic [NUM_DIGITS-1:0] mask, input logic ph);
        int unsigned vv, p;
        int dig [NUM_DIGITS];
        bit ovf, seen;
        logic [6:0] s;
        logic [7*NUM_DIGITS-1:0] r;
        vv = v; p = 1; r = '1; seen = 0;
        ovf = d && (vv >= 1000000);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig[i] = d ? int'((vv / p) % 10) : int'((vv >> (4 * i)) & 15);
            p = p * 10;
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (ovf)                                        s = 7'b0111111;
            else if (lz && !seen && dig[i] == 0 && i != 0)  s = 7'b1111111;
            else                                            s = seg_tab[dig[i]];
            if (dig[i] != 0) seen = 1;
            if (!en[i] || (mask[i] && ph)) s = 7'b1111111;
            r[7*i +: 7] = s;
        end
        return r;
    endfunction

    function automatic logic [63:0] cur_model();
        return 64'(model_hex(m_v, m_dec, m_lz, m_en, m_mask, exp_phase()));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic d, input logic lz,
                           input logic [NUM_DIGITS-1:0] en, input logic [NUM_DIGITS-1:0] mask,
                           input int intrude_at);
        int lat;
        lat = d ? DEC_LAT : 1;
        value = v; dec_mode = d; lz_suppress = lz; digit_en = en; blink_mask = mask;
        load = 1'b1;
        tick();
        load = 1'b0;
        value = W'($urandom); dec_mode = ~d; lz_suppress = ~lz; digit_en = ~en; blink_mask = ~mask;
        for (int c = 1; c <= lat; c++) begin
            check("busy_during", 64'(busy), 64'd1);
            if (c == lat) check("hex_before_update", 64'(HEX), cur_model());
            load = (c == intrude_at);
            tick();
            load = 1'b0;
        end
        m_v = v; m_dec = d; m_lz = lz; m_en = en; m_mask = mask;
        check("busy_after", 64'(busy), 64'd0);
        check("hex_after", 64'(HEX), cur_model());
        check("overflow", 64'(overflow), 64'(d && (v >= 24'd1000000)));
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        tick();
        tick();
        check("reset_hex", 64'(HEX), {22'd0, {42{1'b1}}});
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_blank", 64'(HEX), cur_model());

        // Hex mode with leading-zero suppression
        do_load(24'h00A3F0, 1'b0, 1'b1, 6'h3F, 6'h00, 0);
        check("hex_a3f0_const", 64'(HEX),
              64'({7'b1111111, 7'b1111111, 7'b0001000, 7'b0110000, 7'b0001110, 7'b1000000}));

        // Decimal conversion
        do_load(24'd123456, 1'b1, 1'b0, 6'h3F, 6'h00, 0);
        check("dec_123456_const", 64'(HEX),
              64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}));

        // Overflow then a hex zero load clearing it
        do_load(24'd1000000, 1'b1, 1'b1, 6'h3F, 6'h00, 0);
        check("ovf_dash_const", 64'(HEX), 64'({6{7'b0111111}}));
        do_load(24'h000000, 1'b0, 1'b1, 6'h3F, 6'h00, 0);
        check("hex_zero_const", 64'(HEX), 64'({{5{7'b1111111}}, 7'b1000000}));

        // Boundary just below overflow, and a load intruding at N+5
        do_load(24'd999999, 1'b1, 1'b1, 6'h3F, 6'h00, 0);
        do_load(24'd654321, 1'b1, 1'b0, 6'h3F, 6'h00, 5);
        tick();
        check("intrude_ignored_busy", 64'(busy), 64'd0);
        check("intrude_ignored_hex", 64'(HEX), cur_model());

        // Blink on digit 0
        do_load(24'h000007, 1'b0, 1'b0, 6'h3F, 6'b000001, 0);
        for (int c = 0; c < 16; c++) begin
            check("blink_hex", 64'(HEX), cur_model());
            tick();
        end

        // Randomised loads
        for (int n = 0; n < 14; n++) begin
            logic [W-1:0] v;
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       v = W'($urandom_range(0, 999));
                1:       v = W'($urandom_range(0, 999999));
                2:       v = W'($urandom);
                default: v = W'($urandom_range(999998, 1000001));
            endcase
            do_load(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom),
                    6'($urandom), 0);
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                tick();
                check("idle_hold", 64'(HEX), cur_model());
            end
        end

        // Reset in the middle of a conversion after an overflowing load
        do_load(24'd1000000, 1'b1, 1'b0, 6'h3F, 6'h00, 0);
        value = 24'd123456; dec_mode = 1'b1; lz_suppress = 1'b0; digit_en = 6'h3F; blink_mask = 6'h00;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_v = '0; m_dec = 1'b0; m_lz = 1'b0; m_en = '0; m_mask = '0;
        check("midreset_hex", 64'(HEX), {22'd0, {42{1'b1}}});
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_overflow", 64'(overflow), 64'd0);
        tick();
        check("midreset_no_update", 64'(HEX), {22'd0, {42{1'b1}}});
        do_load(24'd42, 1'b1, 1'b1, 6'h3F, 6'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
